vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 24, 136, 144, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 768, visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 3, 6, 29, vertical front porch, sync and back porch in lines.
REQ-005 Parameters H_POL and V_POL, default 0 each, sync active level (1 = active-high).
REQ-006 Parameter CNT_W, default 11, counter width; elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 does not fit.
REQ-007 Parameter FRAME_W, default 8, frame counter width.
REQ-008 pclk  in  1  pixel clock; the only clock.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 ce  in  1  pixel enable; counters advance only when high.
REQ-011 restart  in  1  synchronous request to return to position (0,0).
REQ-012 hcount, vcount  out  CNT_W  current pixel column and line.
REQ-013 hsync, vsync  out  1  sync outputs at the configured polarity.
REQ-014 hblnk, vblnk  out  1  high outside the active region.
REQ-015 de  out  1  high when both hblnk and vblnk are low.
REQ-016 sof  out  1  start-of-frame pulse.
REQ-017 frame_cnt  out  FRAME_W  count of completed frames.

Function
REQ-018 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-019 On each pclk edge with ce=1, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment.
REQ-020 When vcount is V_TOTAL-1 and hcount wraps, vcount SHALL wrap to 0.
REQ-021 With ce=0, every output SHALL hold its value, and sof SHALL be 0.
REQ-022 All outputs SHALL be registered and mutually consistent: every flag decodes the hcount/vcount presented in the same cycle, with zero relative latency and no glitches.
REQ-023 hblnk SHALL be 1 iff hcount >= H_ACTIVE, and vblnk SHALL be 1 iff vcount >= V_ACTIVE.
REQ-024 hsync SHALL equal H_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL equal ~H_POL.
REQ-025 vsync SHALL equal V_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, independent of hcount; otherwise it SHALL equal ~V_POL.
REQ-026 sof SHALL be high for exactly one cycle, the cycle in which the outputs first show (0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1).
REQ-027 frame_cnt SHALL increment in the same cycle sof rises, wrapping modulo 2^FRAME_W.
REQ-028 restart=1 SHALL set hcount=vcount=0 on the next edge regardless of ce, with flags decoded for (0,0), sof=0, and frame_cnt unchanged.
REQ-029 If restart coincides with a frame wrap, restart SHALL win: sof=0 and frame_cnt is not incremented.
REQ-030 Arithmetic SHALL be unsigned and confined to CNT_W bits; no counter value >= H_TOTAL or >= V_TOTAL SHALL ever appear.

Reset
REQ-031 rst_n=0 SHALL asynchronously force hcount=vcount=0, frame_cnt=0, sof=0, hblnk=vblnk=0, de=1, hsync=~H_POL, vsync=~V_POL.
REQ-032 After rst_n deasserts, the first ce=1 edge SHALL move the outputs to (1,0); the partial first frame SHALL not be flagged by sof.
REQ-033 Reset asserted mid-line or mid-frame SHALL take effect immediately without waiting for a pclk edge.

Verification
Bench parameters: H 8/1/2/1 (H_TOTAL=12), V 4/1/1/1 (V_TOTAL=7), H_POL=1, V_POL=0, FRAME_W=2.
REQ-034 Free run with ce=1 for 84 cycles -> hsync=1 exactly at hcount 9-10; vblnk=1 at vcount 4-6; vsync=0 only at vcount 5; sof=1 once, at the 84th edge; frame_cnt=1.
REQ-035 Run 4 full frames -> frame_cnt sequence 1,2,3,0 at each sof.
REQ-036 ce toggled 1/0 every cycle -> counts advance only on ce=1 edges; one frame takes 168 edges; sof width is 1 cycle.
REQ-037 restart at (5,3) -> next cycle shows (0,0), de=1, sof=0, frame_cnt unchanged; restart applied at (11,6) -> sof stays 0.
REQ-038 rst_n pulsed low at (7,2) between edges -> outputs immediately show the reset values of REQ-031; after release the bench checks REQ-032.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator. It produces the pixel column/line counters and the
// sync, blanking, data-enable and start-of-frame flags for a progressive video
// mode. Every output is registered. The flags are decoded from the *next*
// counter values, so they always describe the hcount/vcount shown in the same
// cycle.
//
// Ports
//   pclk       in   1        pixel clock (the only clock)
//   rst_n      in   1        asynchronous active-low reset
//   ce         in   1        pixel enable; counters advance only when high
//   restart    in   1        synchronous return to (0,0), independent of ce
//   hcount     out  CNT_W    current pixel column
//   vcount     out  CNT_W    current line
//   hsync      out  1        horizontal sync, active level H_POL
//   vsync      out  1        vertical sync, active level V_POL
//   hblnk      out  1        high outside the active columns
//   vblnk      out  1        high outside the active lines
//   de         out  1        high inside the active region
//   sof        out  1        one-cycle pulse when (0,0) follows a frame wrap
//   frame_cnt  out  FRAME_W  completed frames, modulo 2^FRAME_W
// ----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 144,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CNT_W    = 11,
   parameter int FRAME_W  = 8
) (
   input  logic               pclk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic               restart,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               hsync,
   output logic               vsync,
   output logic               hblnk,
   output logic               vblnk,
   output logic               de,
   output logic               sof,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG   = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEG   = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // The terminal counts must be representable in CNT_W bits.
   if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CNT_W)) begin : g_h_too_wide
      $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
   end
   if ((longint'(V_TOTAL) - 1) >= (longint'(1) << CNT_W)) begin : g_v_too_wide
      $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
   end

   // The decodes compare in 32-bit integer space. This keeps a region end
   // equal to 2^CNT_W from being truncated to zero.
   function automatic logic dec_hblnk(input logic [CNT_W-1:0] h);
      return (int'(h) >= H_ACTIVE);
   endfunction

   function automatic logic dec_vblnk(input logic [CNT_W-1:0] v);
      return (int'(v) >= V_ACTIVE);
   endfunction

   function automatic logic dec_hsync(input logic [CNT_W-1:0] h);
      return ((int'(h) >= HS_BEG) && (int'(h) < HS_END)) ? H_POL : ~H_POL;
   endfunction

   function automatic logic dec_vsync(input logic [CNT_W-1:0] v);
      return ((int'(v) >= VS_BEG) && (int'(v) < VS_END)) ? V_POL : ~V_POL;
   endfunction

   logic [CNT_W-1:0]   h_p0;
   logic [CNT_W-1:0]   v_p0;
   logic [FRAME_W-1:0] frame_p0;
   logic               sof_p0;
   logic               adv_p0;

   // ---- stage p0: next raster position, frame wrap detection ----
   always_comb begin
      h_p0     = hcount;
      v_p0     = vcount;
      frame_p0 = frame_cnt;
      sof_p0   = 1'b0;
      adv_p0   = 1'b0;
      if (restart) begin
         // restart overrides a coincident frame wrap: no sof, no frame count
         h_p0   = '0;
         v_p0   = '0;
         adv_p0 = 1'b1;
      end else if (ce) begin
         adv_p0 = 1'b1;
         if (hcount == H_LAST) begin
            h_p0 = '0;
            if (vcount == V_LAST) begin
               v_p0     = '0;
               sof_p0   = 1'b1;
               frame_p0 = frame_cnt + FRAME_W'(1);
            end else begin
               v_p0 = vcount + CNT_W'(1);
            end
         end else begin
            h_p0 = hcount + CNT_W'(1);
         end
      end
   end

   // ---- stage p1: registered counters and flags decoded from p0 ----
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hcount    <= '0;
         vcount    <= '0;
         frame_cnt <= '0;
         sof       <= 1'b0;
         hblnk     <= 1'b0;
         vblnk     <= 1'b0;
         de        <= 1'b1;
         hsync     <= ~H_POL;
         vsync     <= ~V_POL;
      end else begin
         sof <= sof_p0;
         if (adv_p0) begin
            hcount    <= h_p0;
            vcount    <= v_p0;
            frame_cnt <= frame_p0;
            hblnk     <= dec_hblnk(h_p0);
            vblnk     <= dec_vblnk(v_p0);
            de        <= ~(dec_hblnk(h_p0) | dec_vblnk(v_p0));
            hsync     <= dec_hsync(h_p0);
            vsync     <= dec_vsync(v_p0);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen in a small mode. Horizontal timing is
// 8/1/2/1 (12 columns) and vertical timing is 4/1/1/1 (7 lines). hsync is
// active-high, vsync is active-low, and the frame counter is 2 bits wide.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int CNT_W   = 11;
   localparam int FRAME_W = 2;

   logic               pclk = 1'b0;
   logic               rst_n = 1'b1;
   logic               ce = 1'b0;
   logic               restart = 1'b0;
   logic [CNT_W-1:0]   hcount;
   logic [CNT_W-1:0]   vcount;
   logic               hsync;
   logic               vsync;
   logic               hblnk;
   logic               vblnk;
   logic               de;
   logic               sof;
   logic [FRAME_W-1:0] frame_cnt;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b0),
      .CNT_W(CNT_W), .FRAME_W(FRAME_W)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .ce(ce), .restart(restart),
      .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
      .hblnk(hblnk), .vblnk(vblnk), .de(de), .sof(sof), .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   int errors = 0;
   int checks = 0;

   // Reference position and state, kept by the bench
   int mh, mv, mfc;
   bit msof;

   typedef struct {
      bit ce;
      bit rs;
      int h;
      int v;
      bit sof;
      int fc;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Compares every output against the expected position. The expected
   // flags come from the hand-derived boundaries of this mode.
   task automatic check_outputs(input string tag, input int h, input int v,
                                input bit s, input int fc);
      bit e_hbl, e_vbl;
      e_hbl = (h >= 8);
      e_vbl = (v >= 4);
      chk({tag, ".hcount"}, int'(hcount), h);
      chk({tag, ".vcount"}, int'(vcount), v);
      chk({tag, ".hsync"},  int'(hsync), (h == 9 || h == 10) ? 1 : 0);
      chk({tag, ".vsync"},  int'(vsync), (v == 5) ? 0 : 1);
      chk({tag, ".hblnk"},  int'(hblnk), int'(e_hbl));
      chk({tag, ".vblnk"},  int'(vblnk), int'(e_vbl));
      chk({tag, ".de"},     int'(de), (!e_hbl && !e_vbl) ? 1 : 0);
      chk({tag, ".sof"},    int'(sof), int'(s));
      chk({tag, ".frame"},  int'(frame_cnt), fc);
   endtask

   // One clock edge with the given inputs; the reference state advances alongside.
   task automatic step(input bit c, input bit r);
      ce = c;
      restart = r;
      @(posedge pclk);
      #1;
      msof = 1'b0;
      if (r) begin
         mh = 0;
         mv = 0;
      end else if (c) begin
         if (mh == 11) begin
            mh = 0;
            if (mv == 6) begin
               mv   = 0;
               msof = 1'b1;
               mfc  = (mfc + 1) % 4;
            end else begin
               mv++;
            end
         end else begin
            mh++;
         end
      end
   endtask

   task automatic do_reset(input string tag);
      ce = 1'b0;
      restart = 1'b0;
      rst_n = 1'b0;
      #1;
      mh = 0; mv = 0; mfc = 0; msof = 1'b0;
      check_outputs(tag, 0, 0, 1'b0, 0);
      @(posedge pclk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int sof_n, sof_edge;
      int seq[$];
      int exp_seq[4];
      exp_seq = '{1, 2, 3, 0};

      tbl[0] = '{ce: 1'b0, rs: 1'b0, h: 0, v: 0, sof: 1'b0, fc: 0};
      tbl[1] = '{ce: 1'b1, rs: 1'b0, h: 1, v: 0, sof: 1'b0, fc: 0};
      tbl[2] = '{ce: 1'b1, rs: 1'b0, h: 2, v: 0, sof: 1'b0, fc: 0};
      tbl[3] = '{ce: 1'b0, rs: 1'b0, h: 2, v: 0, sof: 1'b0, fc: 0};
      tbl[4] = '{ce: 1'b1, rs: 1'b1, h: 0, v: 0, sof: 1'b0, fc: 0};
      tbl[5] = '{ce: 1'b0, rs: 1'b0, h: 0, v: 0, sof: 1'b0, fc: 0};
      tbl[6] = '{ce: 1'b1, rs: 1'b0, h: 1, v: 0, sof: 1'b0, fc: 0};

      #2;
      do_reset("reset0");

      // Directed vectors right after reset: hold, advance, restart
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].ce, tbl[i].rs);
         check_outputs($sformatf("vec%0d", i), tbl[i].h, tbl[i].v,
                       tbl[i].sof, tbl[i].fc);
      end

      // Four full frames free-running: sof first at edge 84, frame_cnt 1,2,3,0
      do_reset("reset1");
      sof_n = 0;
      sof_edge = -1;
      for (int e = 1; e <= 336; e++) begin
         step(1'b1, 1'b0);
         check_outputs($sformatf("run%0d", e), mh, mv, msof, mfc);
         if (sof === 1'b1) begin
            if (sof_edge < 0) sof_edge = e;
            sof_n++;
            seq.push_back(int'(frame_cnt));
         end
      end
      chk("first_sof_edge", sof_edge, 84);
      chk("sof_count_4frames", sof_n, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("frame_seq%0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);

      // ce toggled every cycle: one frame takes 168 edges, sof lasts one cycle
      do_reset("reset2");
      sof_n = 0;
      sof_edge = -1;
      for (int e = 1; e <= 170; e++) begin
         step((e % 2) == 1, 1'b0);
         check_outputs($sformatf("toggle%0d", e), mh, mv, msof, mfc);
         if (sof === 1'b1) begin
            if (sof_edge < 0) sof_edge = e;
            sof_n++;
         end
      end
      chk("toggle_sof_edge", sof_edge, 167);
      chk("toggle_sof_width", sof_n, 1);

      // restart at (5,3) with ce low: back to (0,0) with frame count kept
      step(1'b0, 1'b1);
      check_outputs("rs_home", 0, 0, 1'b0, mfc);
      repeat (3 * 12 + 5) step(1'b1, 1'b0);
      check_outputs("at_5_3", 5, 3, 1'b0, 1);
      step(1'b0, 1'b1);
      check_outputs("rs_5_3", 0, 0, 1'b0, 1);

      // restart coinciding with the frame wrap at (11,6): restart wins
      repeat (6 * 12 + 11) step(1'b1, 1'b0);
      check_outputs("at_11_6", 11, 6, 1'b0, 1);
      step(1'b1, 1'b1);
      check_outputs("rs_11_6", 0, 0, 1'b0, 1);
      step(1'b1, 1'b0);
      check_outputs("rs_11_6_after", 1, 0, 1'b0, 1);

      // Asynchronous reset between edges at (7,2)
      step(1'b0, 1'b1);
      repeat (2 * 12 + 7) step(1'b1, 1'b0);
      check_outputs("at_7_2", 7, 2, 1'b0, 1);
      ce = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      mh = 0; mv = 0; mfc = 0; msof = 1'b0;
      check_outputs("async_rst", 0, 0, 1'b0, 0);
      @(posedge pclk);
      #1;
      rst_n = 1'b1;
      check_outputs("rst_release", 0, 0, 1'b0, 0);
      step(1'b1, 1'b0);
      check_outputs("first_ce", 1, 0, 1'b0, 0);
      for (int e = 2; e <= 84; e++) begin
         step(1'b1, 1'b0);
         check_outputs($sformatf("post_rst%0d", e), mh, mv, msof, mfc);
      end
      chk("post_rst_frame", int'(frame_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net: the bench must never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, got no finish, expected finish");
      $fatal(1);
   end

endmodule
